// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic processing element.
// Contents:
//   pe_state_t             drain FSM states (IDLE, OWN, PASS)
//   DATA_W_DEF, ACC_W_DEF  default operand / accumulator widths
//   EXT_W                  working width of ext_prod (bounds ACC_W to 64)
//   ext_prod()             sign/zero extension of a product to the accumulator width
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        PASS = 2'd2
    } pe_state_t;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 24;
    localparam int EXT_W      = 64;

    // Extends the low prod_w bits of prod to EXT_W bits; callers truncate to ACC_W.
    function automatic logic [EXT_W-1:0] ext_prod(input logic [EXT_W-1:0] prod,
                                                  input int               prod_w,
                                                  input logic             is_signed);
        logic [EXT_W-1:0] hi_mask;
        hi_mask = {EXT_W{1'b1}} << prod_w;
        if (is_signed && prod[prod_w-1])
            return prod | hi_mask;
        return prod & ~hi_mask;
    endfunction

endpackage

// File: rtl/systolic_pe_mac.sv
// Multiply-accumulate datapath of the systolic PE.
// Optional feature macro: SYSTOLIC_PE_SAT_EN (saturating accumulation + sat flags).
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   i_a, i_b       operands
//   i_beat         both operands valid this cycle
//   i_last         final beat of the tile (acc clears on this edge)
//   o_sum          acc + extended product (value captured on the last beat)
//   o_sat_flag     (SAT_EN) sticky saturation flag of the running tile
//   o_sum_sat      (SAT_EN) saturation status including the current beat
module systolic_pe_mac
    import systolic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_beat,
    input  logic              i_last,
`ifdef SYSTOLIC_PE_SAT_EN
    output logic              o_sat_flag,
    output logic              o_sum_sat,
`endif
    output logic [ACC_W-1:0]  o_sum
);

    localparam int PROD_W = 2 * DATA_W;

    logic [ACC_W-1:0]         r_acc;
    logic signed [PROD_W-1:0] w_prod_s;
    logic [PROD_W-1:0]        w_prod_u;
    logic [PROD_W-1:0]        w_prod;
    logic [ACC_W-1:0]         w_prod_ext;
    logic [ACC_W-1:0]         w_sum;

    // Operands are widened explicitly so the low PROD_W bits are the exact product.
    assign w_prod_s   = $signed({{DATA_W{i_a[DATA_W-1]}}, i_a}) *
                        $signed({{DATA_W{i_b[DATA_W-1]}}, i_b});
    assign w_prod_u   = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};
    assign w_prod     = (SIGNED != 0) ? w_prod_s : w_prod_u;
    assign w_prod_ext = ACC_W'(ext_prod(EXT_W'(w_prod), PROD_W, SIGNED != 0));

`ifdef SYSTOLIC_PE_SAT_EN
    logic [ACC_W:0] w_sum_wide;
    logic           w_ovf;
    logic           r_sat;

    function automatic logic is_ovf(input logic [ACC_W:0] wide);
        if (SIGNED != 0)
            return wide[ACC_W] != wide[ACC_W-1];
        return wide[ACC_W];
    endfunction

    // In the signed case wide[ACC_W] is the true sign of the unbounded sum.
    function automatic logic [ACC_W-1:0] sat_sum(input logic [ACC_W:0] wide);
        if (!is_ovf(wide))
            return wide[ACC_W-1:0];
        if (SIGNED == 0)
            return {ACC_W{1'b1}};
        return wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    endfunction

    assign w_sum_wide = {(SIGNED != 0) & r_acc[ACC_W-1], r_acc} +
                        {(SIGNED != 0) & w_prod_ext[ACC_W-1], w_prod_ext};
    assign w_ovf      = is_ovf(w_sum_wide);
    assign w_sum      = sat_sum(w_sum_wide);
    assign o_sat_flag = r_sat;
    assign o_sum_sat  = r_sat | w_ovf;

    always_ff @(posedge clk) begin
        if (reset)
            r_sat <= 1'b0;
        else if (i_beat)
            r_sat <= i_last ? 1'b0 : (r_sat | w_ovf);
    end
`else
    assign w_sum = r_acc + w_prod_ext;
`endif

    assign o_sum = w_sum;

    // Accumulator stage: the last beat hands the sum out and restarts from zero.
    always_ff @(posedge clk) begin
        if (reset)
            r_acc <= '0;
        else if (i_beat)
            r_acc <= i_last ? '0 : w_sum;
    end

endmodule

// File: rtl/systolic_pe_acc.sv
// Output-stationary systolic PE: forwards operands east/south, accumulates a
// tile dot product and drains it, followed by CHAIN_POS upstream results,
// over a ready/valid partial-sum chain.
// Optional feature macro: SYSTOLIC_PE_SAT_EN (adds sat_flag, psum_sat, psum_in_sat).
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   in_a/_vld/_last, in_b/_vld         west / north operands
//   out_a/_vld/_last, out_b/_vld       operands delayed one cycle
//   psum_in/_vld/_rdy                  upstream result chain
//   psum_out/_vld/_rdy                 downstream result chain
//   align_err                          sticky: one operand valid without the other
//   drain_ovf                          sticky: tile finished while a result was pending
module systolic_pe_acc
    import systolic_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int SIGNED    = 0,
    parameter int CHAIN_POS = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_a,
    input  logic              in_a_vld,
    input  logic              in_a_last,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_b_vld,
    output logic [DATA_W-1:0] out_a,
    output logic              out_a_vld,
    output logic              out_a_last,
    output logic [DATA_W-1:0] out_b,
    output logic              out_b_vld,
    input  logic [ACC_W-1:0]  psum_in,
    input  logic              psum_in_vld,
    output logic              psum_in_rdy,
    output logic [ACC_W-1:0]  psum_out,
    output logic              psum_out_vld,
    input  logic              psum_out_rdy,
`ifdef SYSTOLIC_PE_SAT_EN
    output logic              sat_flag,
    output logic              psum_sat,
    input  logic              psum_in_sat,
`endif
    output logic              align_err,
    output logic              drain_ovf
);

    localparam int CNT_W = (CHAIN_POS > 0) ? $clog2(CHAIN_POS + 1) : 1;

    logic [DATA_W-1:0] r_out_a, r_out_b;
    logic              r_out_a_vld, r_out_a_last, r_out_b_vld;
    logic [ACC_W-1:0]  r_result;
    pe_state_t         r_state;
    logic [CNT_W-1:0]  r_pass_cnt;
    logic              r_align_err, r_drain_ovf;

    logic [ACC_W-1:0]  w_sum;
    logic              w_beat, w_last;
    logic              w_own_xfer, w_pass_xfer, w_pass_final, w_drain_end, w_capture;

    assign w_beat = in_a_vld & in_b_vld;
    assign w_last = w_beat & in_a_last;

`ifdef SYSTOLIC_PE_SAT_EN
    logic w_sum_sat;
    logic r_result_sat;

    systolic_pe_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_mac (
        .clk(clk), .reset(reset), .i_a(in_a), .i_b(in_b),
        .i_beat(w_beat), .i_last(in_a_last),
        .o_sat_flag(sat_flag), .o_sum_sat(w_sum_sat), .o_sum(w_sum)
    );
`else
    systolic_pe_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_mac (
        .clk(clk), .reset(reset), .i_a(in_a), .i_b(in_b),
        .i_beat(w_beat), .i_last(in_a_last), .o_sum(w_sum)
    );
`endif

    // A drain that completes this cycle frees the result register, so a
    // coinciding last beat may take it instead of being dropped.
    assign w_own_xfer   = (r_state == OWN) & psum_out_rdy;
    assign w_pass_xfer  = (r_state == PASS) & psum_in_vld & psum_out_rdy;
    assign w_pass_final = w_pass_xfer & (r_pass_cnt == CNT_W'(1));
    assign w_drain_end  = (w_own_xfer & (CHAIN_POS == 0)) | w_pass_final;
    assign w_capture    = w_last & ((r_state == IDLE) | w_drain_end);

    // Forwarding, result capture and drain FSM stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_a      <= '0;
            r_out_b      <= '0;
            r_out_a_vld  <= 1'b0;
            r_out_a_last <= 1'b0;
            r_out_b_vld  <= 1'b0;
            r_result     <= '0;
            r_state      <= IDLE;
            r_pass_cnt   <= '0;
            r_align_err  <= 1'b0;
            r_drain_ovf  <= 1'b0;
        end else begin
            r_out_a      <= in_a;
            r_out_b      <= in_b;
            r_out_a_vld  <= in_a_vld;
            r_out_a_last <= in_a_last;
            r_out_b_vld  <= in_b_vld;

            if (in_a_vld != in_b_vld)
                r_align_err <= 1'b1;
            if (w_last & ~w_capture)
                r_drain_ovf <= 1'b1;

            if (w_capture) begin
                r_result <= w_sum;
                r_state  <= OWN;
            end else begin
                case (r_state)
                    OWN: begin
                        if (psum_out_rdy) begin
                            r_state    <= (CHAIN_POS > 0) ? PASS : IDLE;
                            r_pass_cnt <= CNT_W'(CHAIN_POS);
                        end
                    end
                    PASS: begin
                        if (w_pass_xfer) begin
                            r_pass_cnt <= r_pass_cnt - CNT_W'(1);
                            if (w_pass_final)
                                r_state <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SYSTOLIC_PE_SAT_EN
    always_ff @(posedge clk) begin
        if (reset)
            r_result_sat <= 1'b0;
        else if (w_capture)
            r_result_sat <= w_sum_sat;
    end
`endif

    always_comb begin
        psum_out     = r_result;
        psum_out_vld = 1'b0;
        psum_in_rdy  = 1'b0;
`ifdef SYSTOLIC_PE_SAT_EN
        psum_sat     = r_result_sat;
`endif
        case (r_state)
            OWN: psum_out_vld = 1'b1;
            PASS: begin
                psum_out     = psum_in;
                psum_out_vld = psum_in_vld;
                psum_in_rdy  = psum_out_rdy;
`ifdef SYSTOLIC_PE_SAT_EN
                psum_sat     = psum_in_sat;
`endif
            end
            default: ;
        endcase
    end

    assign out_a      = r_out_a;
    assign out_a_vld  = r_out_a_vld;
    assign out_a_last = r_out_a_last;
    assign out_b      = r_out_b;
    assign out_b_vld  = r_out_b_vld;
    assign align_err  = r_align_err;
    assign drain_ovf  = r_drain_ovf;

endmodule

// File: tb/tb_systolic_pe_acc.sv
// Self-checking bench for systolic_pe_acc. Four instances share the operand
// and chain inputs: _u unsigned chain head, _s signed chain head, _c unsigned
// with CHAIN_POS=2, _t unsigned with ACC_W=16 (saturation case, SYSTOLIC_PE_SAT_EN).
module tb_systolic_pe_acc;

    localparam int DW = 8;
    localparam int AW = 24;
    localparam int TW = 16;
    localparam longint MASK = (longint'(1) << AW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_a = '0, in_b = '0;
    logic          in_a_vld = 1'b0, in_a_last = 1'b0, in_b_vld = 1'b0;
    logic [AW-1:0] psum_in = '0;
    logic          psum_in_vld = 1'b0, psum_out_rdy = 1'b0;
    logic          psum_in_sat = 1'b0;

    logic [DW-1:0] out_a_u, out_b_u, out_a_s, out_b_s, out_a_c, out_b_c, out_a_t, out_b_t;
    logic          out_a_vld_u, out_a_last_u, out_b_vld_u;
    logic          out_a_vld_s, out_a_last_s, out_b_vld_s;
    logic          out_a_vld_c, out_a_last_c, out_b_vld_c;
    logic          out_a_vld_t, out_a_last_t, out_b_vld_t;
    logic [AW-1:0] psum_out_u, psum_out_s, psum_out_c;
    logic [TW-1:0] psum_out_t;
    logic          psum_out_vld_u, psum_out_vld_s, psum_out_vld_c, psum_out_vld_t;
    logic          psum_in_rdy_u, psum_in_rdy_s, psum_in_rdy_c, psum_in_rdy_t;
    logic          align_err_u, align_err_s, align_err_c, align_err_t;
    logic          drain_ovf_u, drain_ovf_s, drain_ovf_c, drain_ovf_t;
`ifdef SYSTOLIC_PE_SAT_EN
    logic          sat_flag_u, sat_flag_s, sat_flag_c, sat_flag_t;
    logic          psum_sat_u, psum_sat_s, psum_sat_c, psum_sat_t;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    systolic_pe_acc #(.DATA_W(DW), .ACC_W(AW), .SIGNED(0), .CHAIN_POS(0)) u_dut_u (
        .clk(clk), .reset(reset), .in_a(in_a), .in_a_vld(in_a_vld), .in_a_last(in_a_last),
        .in_b(in_b), .in_b_vld(in_b_vld), .out_a(out_a_u), .out_a_vld(out_a_vld_u),
        .out_a_last(out_a_last_u), .out_b(out_b_u), .out_b_vld(out_b_vld_u),
        .psum_in(psum_in), .psum_in_vld(psum_in_vld), .psum_in_rdy(psum_in_rdy_u),
        .psum_out(psum_out_u), .psum_out_vld(psum_out_vld_u), .psum_out_rdy(psum_out_rdy),
`ifdef SYSTOLIC_PE_SAT_EN
        .sat_flag(sat_flag_u), .psum_sat(psum_sat_u), .psum_in_sat(psum_in_sat),
`endif
        .align_err(align_err_u), .drain_ovf(drain_ovf_u)
    );

    systolic_pe_acc #(.DATA_W(DW), .ACC_W(AW), .SIGNED(1), .CHAIN_POS(0)) u_dut_s (
        .clk(clk), .reset(reset), .in_a(in_a), .in_a_vld(in_a_vld), .in_a_last(in_a_last),
        .in_b(in_b), .in_b_vld(in_b_vld), .out_a(out_a_s), .out_a_vld(out_a_vld_s),
        .out_a_last(out_a_last_s), .out_b(out_b_s), .out_b_vld(out_b_vld_s),
        .psum_in(psum_in), .psum_in_vld(psum_in_vld), .psum_in_rdy(psum_in_rdy_s),
        .psum_out(psum_out_s), .psum_out_vld(psum_out_vld_s), .psum_out_rdy(psum_out_rdy),
`ifdef SYSTOLIC_PE_SAT_EN
        .sat_flag(sat_flag_s), .psum_sat(psum_sat_s), .psum_in_sat(psum_in_sat),
`endif
        .align_err(align_err_s), .drain_ovf(drain_ovf_s)
    );

    systolic_pe_acc #(.DATA_W(DW), .ACC_W(AW), .SIGNED(0), .CHAIN_POS(2)) u_dut_c (
        .clk(clk), .reset(reset), .in_a(in_a), .in_a_vld(in_a_vld), .in_a_last(in_a_last),
        .in_b(in_b), .in_b_vld(in_b_vld), .out_a(out_a_c), .out_a_vld(out_a_vld_c),
        .out_a_last(out_a_last_c), .out_b(out_b_c), .out_b_vld(out_b_vld_c),
        .psum_in(psum_in), .psum_in_vld(psum_in_vld), .psum_in_rdy(psum_in_rdy_c),
        .psum_out(psum_out_c), .psum_out_vld(psum_out_vld_c), .psum_out_rdy(psum_out_rdy),
`ifdef SYSTOLIC_PE_SAT_EN
        .sat_flag(sat_flag_c), .psum_sat(psum_sat_c), .psum_in_sat(psum_in_sat),
`endif
        .align_err(align_err_c), .drain_ovf(drain_ovf_c)
    );

    systolic_pe_acc #(.DATA_W(DW), .ACC_W(TW), .SIGNED(0), .CHAIN_POS(0)) u_dut_t (
        .clk(clk), .reset(reset), .in_a(in_a), .in_a_vld(in_a_vld), .in_a_last(in_a_last),
        .in_b(in_b), .in_b_vld(in_b_vld), .out_a(out_a_t), .out_a_vld(out_a_vld_t),
        .out_a_last(out_a_last_t), .out_b(out_b_t), .out_b_vld(out_b_vld_t),
        .psum_in(psum_in[TW-1:0]), .psum_in_vld(psum_in_vld), .psum_in_rdy(psum_in_rdy_t),
        .psum_out(psum_out_t), .psum_out_vld(psum_out_vld_t), .psum_out_rdy(psum_out_rdy),
`ifdef SYSTOLIC_PE_SAT_EN
        .sat_flag(sat_flag_t), .psum_sat(psum_sat_t), .psum_in_sat(psum_in_sat),
`endif
        .align_err(align_err_t), .drain_ovf(drain_ovf_t)
    );

    task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic av, input logic bv, input logic last);
        in_a = a; in_b = b; in_a_vld = av; in_b_vld = bv; in_a_last = last;
    endtask

    task automatic idle();
        drive('0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        psum_in_vld = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b1);
        psum_out_rdy = 1'b1;
        tick();
        tick();
        n_checks++; if (out_a_u !== 8'h00) begin n_fail++; $display("FAIL reset_out_a got %0h want 0", out_a_u); end
        n_checks++; if (out_a_vld_u !== 1'b0) begin n_fail++; $display("FAIL reset_out_a_vld got %0b want 0", out_a_vld_u); end
        n_checks++; if (out_a_last_u !== 1'b0) begin n_fail++; $display("FAIL reset_out_a_last got %0b want 0", out_a_last_u); end
        n_checks++; if (psum_out_vld_u !== 1'b0) begin n_fail++; $display("FAIL reset_psum_vld got %0b want 0", psum_out_vld_u); end
        n_checks++; if (psum_out_u !== 24'd0) begin n_fail++; $display("FAIL reset_psum_out got %0h want 0", psum_out_u); end
        n_checks++; if (align_err_u !== 1'b0) begin n_fail++; $display("FAIL reset_align_err got %0b want 0", align_err_u); end
        n_checks++; if (drain_ovf_u !== 1'b0) begin n_fail++; $display("FAIL reset_drain_ovf got %0b want 0", drain_ovf_u); end
        n_checks++; if (psum_in_rdy_c !== 1'b0) begin n_fail++; $display("FAIL reset_psum_in_rdy got %0b want 0", psum_in_rdy_c); end
        reset = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_unsigned_tile();
        logic [DW-1:0] av [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
        logic [DW-1:0] bv [4] = '{8'd5, 8'd6, 8'd7, 8'd8};
        logic [DW-1:0] a, b;
        longint exp_sum;
        do_reset();
        psum_out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(av[i], bv[i], 1'b1, 1'b1, i == 3);
            #1;
            n_checks++; if (psum_out_vld_u !== 1'b0) begin n_fail++; $display("FAIL tile_vld_early beat %0d got %0b want 0", i, psum_out_vld_u); end
            tick();
        end
        idle();
        n_checks++; if (psum_out_vld_u !== 1'b1) begin n_fail++; $display("FAIL tile_vld got %0b want 1", psum_out_vld_u); end
        n_checks++; if (psum_out_u !== 24'd70) begin n_fail++; $display("FAIL tile_sum got %0d want 70", psum_out_u); end
        tick();
        n_checks++; if (psum_out_u !== 24'd70 || psum_out_vld_u !== 1'b1) begin n_fail++; $display("FAIL tile_hold got %0d/%0b want 70/1", psum_out_u, psum_out_vld_u); end
        psum_out_rdy = 1'b1;
        tick();
        n_checks++; if (psum_out_vld_u !== 1'b0) begin n_fail++; $display("FAIL tile_drained got %0b want 0", psum_out_vld_u); end
        exp_sum = 0;
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            exp_sum += longint'(a) * longint'(b);
            drive(a, b, 1'b1, 1'b1, i == 2);
            tick();
        end
        idle();
        n_checks++; if (psum_out_u !== AW'(exp_sum & MASK)) begin n_fail++; $display("FAIL tile2_from_zero got %0d want %0d", psum_out_u, exp_sum); end
        tick();
    endtask

    task automatic test_signed();
        do_reset();
        psum_out_rdy = 1'b0;
        drive(8'hFD, 8'h07, 1'b1, 1'b1, 1'b0);
        tick();
        n_checks++; if (out_a_s !== 8'hFD || out_b_s !== 8'h07) begin n_fail++; $display("FAIL fwd_beat1 got %0h/%0h want fd/07", out_a_s, out_b_s); end
        n_checks++; if (out_a_vld_s !== 1'b1 || out_b_vld_s !== 1'b1 || out_a_last_s !== 1'b0) begin n_fail++; $display("FAIL fwd_tags1 got %0b%0b%0b want 110", out_a_vld_s, out_b_vld_s, out_a_last_s); end
        drive(8'h04, 8'hFE, 1'b1, 1'b1, 1'b1);
        tick();
        n_checks++; if (out_a_s !== 8'h04 || out_b_s !== 8'hFE || out_a_last_s !== 1'b1) begin n_fail++; $display("FAIL fwd_beat2 got %0h/%0h/%0b want 04/fe/1", out_a_s, out_b_s, out_a_last_s); end
        n_checks++; if (psum_out_s !== 24'hFFFFE3 || psum_out_vld_s !== 1'b1) begin n_fail++; $display("FAIL signed_sum got %0h/%0b want ffffe3/1", psum_out_s, psum_out_vld_s); end
        drive(8'h3C, 8'hC3, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++; if (out_a_s !== 8'h3C || out_b_s !== 8'hC3 || out_a_vld_s !== 1'b0) begin n_fail++; $display("FAIL fwd_novalid got %0h/%0h/%0b want 3c/c3/0", out_a_s, out_b_s, out_a_vld_s); end
        idle();
        tick();
    endtask

    task automatic test_chain();
        logic [DW-1:0] a0, b0, a1, b1;
        longint expq[$];
        longint upq[$];
        int delivered;
        logic rdy;
        do_reset();
        psum_out_rdy = 1'b0;
        a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
        expq = '{(longint'(a0) * b0 + longint'(a1) * b1) & MASK, 11, 22};
        upq  = '{11, 22};
        drive(a0, b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(a1, b1, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        delivered = 0;
        for (int cyc = 0; cyc < 40 && delivered < 3; cyc++) begin
            rdy = cyc[0];
            psum_out_rdy = rdy;
            psum_in_vld  = upq.size() > 0;
            psum_in      = (upq.size() > 0) ? AW'(upq[0]) : '0;
            #1;
            n_checks++; if (psum_out_vld_c !== 1'b1) begin n_fail++; $display("FAIL chain_vld item %0d got %0b want 1", delivered, psum_out_vld_c); end
            n_checks++; if (psum_out_c !== AW'(expq[delivered])) begin n_fail++; $display("FAIL chain_data item %0d got %0d want %0d", delivered, psum_out_c, expq[delivered]); end
            n_checks++; if (psum_in_rdy_c !== ((delivered >= 1) ? rdy : 1'b0)) begin n_fail++; $display("FAIL chain_in_rdy item %0d got %0b rdy %0b", delivered, psum_in_rdy_c, rdy); end
            if (rdy) begin
                if (delivered >= 1) void'(upq.pop_front());
                delivered++;
            end
            tick();
        end
        n_checks++; if (delivered != 3) begin n_fail++; $display("FAIL chain_timeout got %0d transfers want 3", delivered); end
        psum_in_vld = 1'b0;
        psum_in = 24'd99;
        psum_out_rdy = 1'b1;
        #1;
        n_checks++; if (psum_out_vld_c !== 1'b0 || psum_in_rdy_c !== 1'b0) begin n_fail++; $display("FAIL chain_idle got vld %0b rdy %0b want 0/0", psum_out_vld_c, psum_in_rdy_c); end
        tick();
    endtask

    task automatic test_misalign();
        do_reset();
        psum_out_rdy = 1'b0;
        drive(8'd3, 8'd4, 1'b1, 1'b1, 1'b0);
        tick();
        n_checks++; if (align_err_u !== 1'b0) begin n_fail++; $display("FAIL align_clean got %0b want 0", align_err_u); end
        drive(8'd100, 8'd100, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++; if (align_err_u !== 1'b1) begin n_fail++; $display("FAIL align_set got %0b want 1", align_err_u); end
        drive(8'd5, 8'd6, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        n_checks++; if (psum_out_u !== 24'd42) begin n_fail++; $display("FAIL align_sum got %0d want 42", psum_out_u); end
        repeat (3) tick();
        n_checks++; if (align_err_u !== 1'b1) begin n_fail++; $display("FAIL align_sticky got %0b want 1", align_err_u); end
        do_reset();
        n_checks++; if (align_err_u !== 1'b0) begin n_fail++; $display("FAIL align_reset got %0b want 0", align_err_u); end
    endtask

    task automatic test_overflow();
        do_reset();
        psum_out_rdy = 1'b0;
        drive(8'd2, 8'd2, 1'b1, 1'b1, 1'b1);
        tick();
        drive(8'd3, 8'd3, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        n_checks++; if (psum_out_u !== 24'd4 || psum_out_vld_u !== 1'b1) begin n_fail++; $display("FAIL ovf_keep got %0d/%0b want 4/1", psum_out_u, psum_out_vld_u); end
        n_checks++; if (drain_ovf_u !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b want 1", drain_ovf_u); end
        tick();
        n_checks++; if (psum_out_u !== 24'd4) begin n_fail++; $display("FAIL ovf_hold got %0d want 4", psum_out_u); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (psum_out_vld_u !== 1'b0 || drain_ovf_u !== 1'b0) begin n_fail++; $display("FAIL ovf_reset got vld %0b ovf %0b want 0/0", psum_out_vld_u, drain_ovf_u); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        psum_out_rdy = 1'b0;
        drive(8'd5, 8'd5, 1'b1, 1'b1, 1'b1);
        tick();
        n_checks++; if (psum_out_u !== 24'd25) begin n_fail++; $display("FAIL b2b_first got %0d want 25", psum_out_u); end
        psum_out_rdy = 1'b1;
        drive(8'd6, 8'd6, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        n_checks++; if (psum_out_u !== 24'd36 || psum_out_vld_u !== 1'b1) begin n_fail++; $display("FAIL b2b_second got %0d/%0b want 36/1", psum_out_u, psum_out_vld_u); end
        n_checks++; if (drain_ovf_u !== 1'b0) begin n_fail++; $display("FAIL b2b_no_ovf got %0b want 0", drain_ovf_u); end
        tick();
        n_checks++; if (psum_out_vld_u !== 1'b0) begin n_fail++; $display("FAIL b2b_drained got %0b want 0", psum_out_vld_u); end
    endtask

    task automatic test_random();
        longint acc_u, acc_s, pend_u, pend_s;
        bit pending, exp_ovf, v, last, rdy, xfer, ok;
        logic [DW-1:0] a, b, prev_a;
        byte sa, sb;
        do_reset();
        acc_u = 0; acc_s = 0; pend_u = 0; pend_s = 0;
        pending = 0; exp_ovf = 0; prev_a = '0;
        for (int i = 0; i < 300; i++) begin
            v    = $urandom_range(0, 3) != 0;
            a    = 8'($urandom);
            b    = 8'($urandom);
            last = v && ($urandom_range(0, 3) == 0);
            rdy  = 1'($urandom_range(0, 1));
            drive(a, b, v, v, last);
            psum_out_rdy = rdy;
            #1;
            n_checks++; if (out_a_u !== prev_a) begin n_fail++; $display("FAIL rnd_fwd cyc %0d got %0h want %0h", i, out_a_u, prev_a); end
            n_checks++; if (psum_out_vld_u !== pending || psum_out_vld_s !== pending) begin n_fail++; $display("FAIL rnd_vld cyc %0d got %0b/%0b want %0b", i, psum_out_vld_u, psum_out_vld_s, pending); end
            if (pending) begin
                n_checks++; if (psum_out_u !== AW'(pend_u)) begin n_fail++; $display("FAIL rnd_u cyc %0d got %0d want %0d", i, psum_out_u, pend_u); end
                n_checks++; if (psum_out_s !== AW'(pend_s)) begin n_fail++; $display("FAIL rnd_s cyc %0d got %0h want %0h", i, psum_out_s, pend_s); end
            end
            xfer = pending && rdy;
            ok   = !pending || xfer;
            if (xfer) pending = 0;
            if (v) begin
                sa = a; sb = b;
                acc_u += longint'(a) * longint'(b);
                acc_s += longint'(sa) * longint'(sb);
                if (last) begin
                    if (ok) begin
                        pending = 1;
                        pend_u  = acc_u & MASK;
                        pend_s  = acc_s & MASK;
                    end else begin
                        exp_ovf = 1;
                    end
                    acc_u = 0;
                    acc_s = 0;
                end
            end
            prev_a = a;
            tick();
        end
        idle();
        n_checks++; if (drain_ovf_u !== exp_ovf || drain_ovf_s !== exp_ovf) begin n_fail++; $display("FAIL rnd_ovf got %0b/%0b want %0b", drain_ovf_u, drain_ovf_s, exp_ovf); end
    endtask

    task automatic test_saturation();
        longint exp_wrap;
        do_reset();
        psum_out_rdy = 1'b0;
        drive(8'd255, 8'd255, 1'b1, 1'b1, 1'b0);
        tick();
        drive(8'd255, 8'd255, 1'b1, 1'b1, 1'b0);
        tick();
`ifdef SYSTOLIC_PE_SAT_EN
        n_checks++; if (sat_flag_t !== 1'b1) begin n_fail++; $display("FAIL sat_flag_mid got %0b want 1", sat_flag_t); end
`endif
        drive(8'd255, 8'd2, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
`ifdef SYSTOLIC_PE_SAT_EN
        n_checks++; if (psum_out_t !== 16'hFFFF) begin n_fail++; $display("FAIL sat_value got %0d want 65535", psum_out_t); end
        n_checks++; if (psum_sat_t !== 1'b1) begin n_fail++; $display("FAIL sat_sideband got %0b want 1", psum_sat_t); end
        n_checks++; if (sat_flag_t !== 1'b0) begin n_fail++; $display("FAIL sat_flag_clear got %0b want 0", sat_flag_t); end
`else
        exp_wrap = (longint'(255) * 255 * 2 + 255 * 2) & 16'hFFFF;
        n_checks++; if (psum_out_t !== TW'(exp_wrap)) begin n_fail++; $display("FAIL wrap_value got %0d want %0d", psum_out_t, exp_wrap); end
`endif
        n_checks++; if (psum_out_vld_t !== 1'b1) begin n_fail++; $display("FAIL sat_vld got %0b want 1", psum_out_vld_t); end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before the end of the sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unsigned_tile();
        test_signed();
        test_chain();
        test_misalign();
        test_overflow();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
